// File: rtl/sram_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// sram_pkg : shared types and limits for the SRAM master controller
// rev 1.0
// ---------------------------------------------------------------------
package sram_pkg;

    localparam int RD_LAT_MAX    = 7;
    localparam int DATA_WDTH     = 8;
    localparam int ADDR_WDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD      = 3'd2,
        RD_WAIT = 3'd3,
        TURN    = 3'd4
    } sram_st_e;

    typedef struct packed {
        logic                     wr;
        logic [ADDR_WDTH_DEF-1:0] addr;
        logic [DATA_WDTH-1:0]     wdata;
    } sram_req_t;

endpackage
`default_nettype wire

// File: rtl/sram_master_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------
// sram_master_ctrl_if : request/response handshake and SRAM control bus
// rev 1.0
// ---------------------------------------------------------------------
interface sram_master_ctrl_if #(
    parameter int RAM_ADDR_WDTH = 8
) ();

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_wr;
    logic [RAM_ADDR_WDTH-1:0] req_addr;
    logic [7:0]               req_wdata;
    logic                     rsp_valid;
    logic [7:0]               rsp_rdata;
    logic                     wr_done;
    logic                     ce_N;
    logic                     rdWr_N;
    logic [RAM_ADDR_WDTH-1:0] ramAddr;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, wr_done,
        output ce_N, rdWr_N, ramAddr
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, wr_done,
        input  ce_N, rdWr_N, ramAddr
    );

endinterface
`default_nettype wire

// File: rtl/sram_lat_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------
// sram_lat_cnt : 3-bit loadable down-counter with zero flag
// rev 1.0
// ---------------------------------------------------------------------
module sram_lat_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign zero = (cnt == 3'd0);

endmodule
`default_nettype wire

// File: rtl/sram_master_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------
// sram_master_ctrl : turns valid/ready requests into async SRAM bus cycles
// rev 1.0
// ---------------------------------------------------------------------
module sram_master_ctrl
    import sram_pkg::*;
#(
    parameter int RAM_ADDR_WDTH = 8,
    parameter int RD_LAT        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_master_ctrl_if.master    bus,
    inout  wire  [DATA_WDTH-1:0]  ramData
);

    localparam int LAT_CLAMP =
        (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
    localparam logic [2:0] LAT_LOAD = 3'(LAT_CLAMP - 1);

    sram_st_e                 state;
    logic                     ready_q;
    logic                     rsp_valid_q;
    logic                     wr_done_q;
    logic                     ce_n_q;
    logic                     rd_wr_n_q;
    logic                     drv_en;
    logic [DATA_WDTH-1:0]     wdata_q;
    logic [DATA_WDTH-1:0]     rdata_q;
    logic [RAM_ADDR_WDTH-1:0] addr_q;
    logic                     lat_load;
    logic                     lat_dec;
    logic                     lat_zero;

    // The counter is loaded during the command cycle so RD_WAIT sees it settled.
    assign lat_load = (state == RD);
    assign lat_dec  = (state == RD_WAIT);

    sram_lat_cnt u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (lat_load),
        .load_val (LAT_LOAD),
        .dec      (lat_dec),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
            rdata_q     <= '0;
            ce_n_q      <= 1'b1;
            rd_wr_n_q   <= 1'b1;
            addr_q      <= '0;
            drv_en      <= 1'b0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        ready_q   <= 1'b0;
                        ce_n_q    <= 1'b0;
                        addr_q    <= bus.req_addr;
                        rd_wr_n_q <= ~bus.req_wr;
                        wdata_q   <= bus.req_wdata;
                        if (bus.req_wr) begin
                            drv_en <= 1'b1;
                            state  <= WR;
                        end else begin
                            state  <= RD;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WR: begin
                    ce_n_q    <= 1'b1;
                    drv_en    <= 1'b0;
                    wr_done_q <= 1'b1;
                    ready_q   <= 1'b1;
                    state     <= IDLE;
                end
                RD: begin
                    ce_n_q <= 1'b1;
                    state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lat_zero) begin
                        rdata_q     <= ramData;
                        rsp_valid_q <= 1'b1;
                        state       <= TURN;
                    end
                end
                // Dead bus cycle so the SRAM's read drive has released before we may drive.
                TURN: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ramData       = drv_en ? wdata_q : 'z;

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.wr_done   = wr_done_q;
    assign bus.ce_N      = ce_n_q;
    assign bus.rdWr_N    = rd_wr_n_q;
    assign bus.ramAddr   = addr_q;

    // A selected write cycle must always have our data on the bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(!ce_n_q && !rd_wr_n_q && !drv_en));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_master_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_sram_master_ctrl : directed bench, two controllers (RD_LAT 1 and 3)
// rev 1.0
// ---------------------------------------------------------------------
module tb_sram_master_ctrl;
    import sram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst, rv, rwr;
    logic [1:0][7:0] radr, rwd;
    logic [1:0]      rdy, rspv, wrd, ce, rwn, drv_m, drv_s;
    logic [1:0][7:0] rsp_d, addr, bus_d;
    int tests = 0;
    int fails = 0;
    int contention = 0;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        sram_master_ctrl_if #(.RAM_ADDR_WDTH(8)) bus ();
        wire  [7:0] ramData;
        logic [7:0] mem [256];
        logic [7:0] sq;
        logic       sdrv = 1'b0;
        logic       pend = 1'b0;
        logic [2:0] scnt = 3'd0;

        assign bus.req_valid = rv[g];
        assign bus.req_wr    = rwr[g];
        assign bus.req_addr  = radr[g];
        assign bus.req_wdata = rwd[g];
        assign rdy[g]   = bus.req_ready;
        assign rspv[g]  = bus.rsp_valid;
        assign rsp_d[g] = bus.rsp_rdata;
        assign wrd[g]   = bus.wr_done;
        assign ce[g]    = bus.ce_N;
        assign rwn[g]   = bus.rdWr_N;
        assign addr[g]  = bus.ramAddr;
        assign bus_d[g] = ramData;
        assign drv_m[g] = dut.drv_en;
        assign drv_s[g] = sdrv;
        assign ramData  = sdrv ? sq : 8'hzz;

        sram_master_ctrl #(.RAM_ADDR_WDTH(8), .RD_LAT(LAT)) dut (
            .clk     (clk),
            .reset   (rst[g]),
            .bus     (bus),
            .ramData (ramData)
        );

        // SRAM responder: read data valid LAT edges after the command edge
        always @(posedge clk) begin
            if (sdrv) sdrv <= 1'b0;
            if (pend) begin
                if (scnt == 3'd1) begin
                    sdrv <= 1'b1;
                    pend <= 1'b0;
                end else begin
                    scnt <= scnt - 3'd1;
                end
            end
            if (!ce[g]) begin
                if (rwn[g]) begin
                    sq <= mem[addr[g]];
                    if (LAT == 1) sdrv <= 1'b1;
                    else begin
                        pend <= 1'b1;
                        scnt <= 3'(LAT - 1);
                    end
                end else begin
                    mem[addr[g]] <= bus_d[g];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (drv_m[g] && drv_s[g]) contention++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int s);
        int n = 0;
        while (rdy[s] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (rdy[s] !== 1'b1) chk("ready_timeout", 32'(rdy[s]), 32'd1);
    endtask

    task automatic do_write(input int s, input logic [7:0] a, input logic [7:0] d);
        rwr[s] = 1'b1; radr[s] = a; rwd[s] = d; rv[s] = 1'b1;
        wait_ready(s);
        tick();
        rv[s] = 1'b0;
        chk("wr_bus_data", 32'(bus_d[s]), 32'(d));
        chk("wr_bus_addr", 32'(addr[s]), 32'(a));
        tick();
        chk("wr_done", 32'(wrd[s]), 32'd1);
    endtask

    task automatic do_read(input int s, input logic [7:0] a, input logic [7:0] d, input int lat_cyc);
        int cyc;
        rwr[s] = 1'b0; radr[s] = a; rv[s] = 1'b1;
        wait_ready(s);
        tick();
        rv[s] = 1'b0;
        cyc = 1;
        while (rspv[s] !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rd_latency", 32'(cyc), 32'(lat_cyc));
        chk("rd_data", 32'(rsp_d[s]), 32'(d));
        chk("turn_not_ready", 32'(rdy[s]), 32'd0);
        tick();
        chk("rsp_one_pulse", 32'(rspv[s]), 32'd0);
        chk("ready_after_turn", 32'(rdy[s]), 32'd1);
    endtask

    initial begin
        sram_req_t reqs [3];
        logic [7:0] e_ce, e_rwn, e_rdy;
        int idx, n;
        logic acc;

        rst = 2'b11; rv = 2'b11; rwr = 2'b11;
        radr = {8'h3C, 8'h3C}; rwd = {8'hA5, 8'hA5};

        // reset held with a write request pending
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ce_n", 32'(ce[0]), 32'd1);
            chk("rst_ready", 32'(rdy[0]), 32'd0);
            chk("rst_drive", 32'(drv_m[0]), 32'd0);
        end
        chk("rst_rdwr_n", 32'(rwn[0]), 32'd1);
        chk("rst_addr", 32'(addr[0]), 32'd0);
        chk("rst_rsp", 32'({rspv[0], wrd[0], rsp_d[0]}), 32'd0);

        rst = 2'b00;
        tick();
        chk("ready_first", 32'(rdy[0]), 32'd1);
        chk("idle_ce_n", 32'(ce[0]), 32'd1);
        tick();
        rv = 2'b00;
        chk("wr_ce_n", 32'(ce[0]), 32'd0);
        chk("wr_rdwr_n", 32'(rwn[0]), 32'd0);
        chk("wr_addr", 32'(addr[0]), 32'h3C);
        chk("wr_data", 32'(bus_d[0]), 32'hA5);
        chk("wr_drive", 32'(drv_m[0]), 32'd1);
        chk("wr_done_early", 32'(wrd[0]), 32'd0);
        tick();
        chk("wr_done_pulse", 32'(wrd[0]), 32'd1);
        chk("wr_release_ce", 32'(ce[0]), 32'd1);
        chk("wr_release_drv", 32'(drv_m[0]), 32'd0);
        tick();
        chk("wr_done_once", 32'(wrd[0]), 32'd0);

        do_read(0, 8'h3C, 8'hA5, 3);
        do_read(1, 8'h3C, 8'hA5, 5);

        // write / read / write with req_valid held high
        reqs[0] = '{wr: 1'b1, addr: 8'h10, wdata: 8'h11};
        reqs[1] = '{wr: 1'b0, addr: 8'h10, wdata: 8'h00};
        reqs[2] = '{wr: 1'b1, addr: 8'h20, wdata: 8'h22};
        e_ce  = 8'b1011_1010;
        e_rwn = 8'b0011_1100;
        e_rdy = 8'b1010_0010;
        idx = 0;
        rwr[0] = reqs[0].wr; radr[0] = reqs[0].addr; rwd[0] = reqs[0].wdata; rv[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            acc = rdy[0] & rv[0];
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    rwr[0] = reqs[idx].wr; radr[0] = reqs[idx].addr; rwd[0] = reqs[idx].wdata;
                end else begin
                    rv[0] = 1'b0;
                end
            end
            chk($sformatf("b2b_ce_n_c%0d", i + 1), 32'(ce[0]), 32'(e_ce[i]));
            chk($sformatf("b2b_rdwr_n_c%0d", i + 1), 32'(rwn[0]), 32'(e_rwn[i]));
            chk($sformatf("b2b_ready_c%0d", i + 1), 32'(rdy[0]), 32'(e_rdy[i]));
        end
        chk("b2b_rd_data", 32'(rsp_d[0]), 32'h11);
        do_read(0, 8'h20, 8'h22, 3);

        // address extremes
        do_write(0, 8'hFF, 8'h5A);
        do_write(0, 8'h00, 8'hC3);
        do_read(0, 8'hFF, 8'h5A, 3);
        do_read(0, 8'h00, 8'hC3, 3);

        // reset while the RD_LAT=3 controller sits in RD_WAIT
        rwr[1] = 1'b0; radr[1] = 8'h3C; rv[1] = 1'b1;
        wait_ready(1);
        tick();
        rv[1] = 1'b0;
        tick();
        tick();
        chk("rdwait_ce_n", 32'(ce[1]), 32'd1);
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        chk("abort_ce_n", 32'(ce[1]), 32'd1);
        chk("abort_drive", 32'(drv_m[1]), 32'd0);
        chk("abort_ready", 32'(rdy[1]), 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rspv[1]) n++;
        end
        chk("abort_no_rsp", 32'(n), 32'd0);
        chk("abort_rsp_data", 32'(rsp_d[1]), 32'd0);
        do_read(1, 8'h3C, 8'hA5, 5);

        chk("no_contention", 32'(contention), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
